dffse_bank_ctrl: RTL and testbench
==================================

Name: dffse_bank_ctrl

Overview:
- Write controller that shares one bank of DEPTH x WIDTH DFFSE registers between NREQ requesters.
- Arbitrates write requests round-robin and drives one-hot clock-enables plus a shared data bus to the bank.
- Runs a rate-limited preset sweep, one register SET per cycle, after reset or on demand; this avoids a global SET fanout burst.
- Sits between requester logic and the DFFSE register bank in the primitive library.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DEPTH, 8: number of bank registers (1..256); need not be a power of two.
- WIDTH, 8: register data width.
- INIT_PRESET, 1: 1 = controller leaves reset in PRESET state and sweeps; 0 = leaves reset in IDLE.
- AW, clog2(DEPTH) (min 1): derived address width; do not override.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous active-high reset.
- REQ  in  NREQ  per-requester write request; held until granted.
- ADDR  in  NREQ*AW  flattened target addresses; requester i uses bits [i*AW +: AW].
- WDATA  in  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- GNT  out  NREQ  combinational one-hot grant. REQ[i] & GNT[i] = transfer.
- PRESET_REQ  in  1  start a preset sweep (level sampled in IDLE).
- PRESET_BUSY  out  1  high while in PRESET state.
- BANK_CE  out  DEPTH  registered one-hot clock-enable to the bank.
- BANK_SET  out  DEPTH  registered one-hot SET to the bank.
- BANK_D  out  WIDTH  registered write data to the bank.
- ADDR_ERR  out  1  registered 1-cycle pulse: the granted ADDR was >= DEPTH.

Behaviour:
- Reset (async, immediate):
  - BANK_CE, BANK_SET, BANK_D, ADDR_ERR = 0.
  - Round-robin pointer = 0; sweep counter = 0.
  - State = PRESET if INIT_PRESET else IDLE.
  - PRESET_BUSY follows the state and is combinational from it.
  - Reset asserted mid-sweep or mid-write aborts it; no partial SET/CE survives.
- States: IDLE and PRESET only.
- IDLE:
  - PRESET_REQ=1 has priority. Next state = PRESET, counter = 0, GNT = 0 this cycle.
  - Otherwise GNT selects the first asserted REQ searching from pointer upward, with wrap.
  - GNT = 0 when no REQ is asserted.
  - On a transfer by requester k: pointer <= (k+1) mod NREQ; pointer is unchanged without a transfer.
  - Write latency is 1. A transfer at edge N makes BANK_CE[ADDR_k]=1 and BANK_D=WDATA_k for the cycle after edge N; the bank captures at edge N+1.
  - BANK_CE returns to 0 the next cycle unless another transfer occurs. Back-to-back writes, one per cycle, are allowed.
  - ADDR_k >= DEPTH: transfer still granted; BANK_CE = 0; ADDR_ERR pulses 1 cycle; BANK_D is updated anyway.
- PRESET:
  - GNT = 0 and REQ is ignored. BANK_CE = 0.
  - Each cycle BANK_SET <= onehot(counter), then counter++.
  - After the edge that registers SET for DEPTH-1: next state = IDLE and BANK_SET returns to 0 on the following edge.
  - A sweep takes exactly DEPTH cycles with PRESET_BUSY high.
  - PRESET_REQ during PRESET is ignored (no restart).
- BANK_CE and BANK_SET are never both nonzero in the same cycle. At most one bit of each is high.
- No combinational path from REQ, ADDR or WDATA to the BANK_* outputs. GNT is the only combinational output.

Decomposition:
- Shared package:
  - state encoding (ST_IDLE, ST_PRESET);
  - clog2 constant function;
  - one-hot decode function.
- One sub-module, dffse_rr_arbiter (NREQ): REQ, pointer in -> one-hot GNT plus granted index out; purely combinational.
- The controller owns the pointer register, FSM, counter and output registers.

Test Plan:
- Reset release with INIT_PRESET=1, DEPTH=8, no REQ -> BANK_SET walks 0x01, 0x02 ... 0x80 over 8 consecutive cycles; PRESET_BUSY high 8 cycles; GNT stays 0 throughout; then IDLE.
- IDLE, REQ=4'b1111 held, ADDR_i=i, WDATA_i=0xA0+i:
  - GNT order 0, 1, 2, 3, 0, one per cycle;
  - BANK_CE = 0x01, 0x02, 0x04, 0x08, 0x01 each one cycle later;
  - BANK_D = 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- DEPTH=6, requester 2 writes ADDR=7 -> GNT[2]=1; next cycle BANK_CE=0 and ADDR_ERR=1 for exactly 1 cycle; pointer advances to 3.
- PRESET_REQ=1 together with REQ[1]=1 in IDLE:
  - GNT=0 and the sweep runs DEPTH cycles;
  - REQ[1] is granted in the first IDLE cycle after the sweep;
  - BANK_CE appears only after BANK_SET has returned to 0.
- RESET asserted asynchronously at sweep step 3 (between clock edges) -> BANK_SET=0 immediately; on release a fresh sweep restarts at bit 0 (INIT_PRESET=1) or the controller sits in IDLE (INIT_PRESET=0).

Source files
------------

// File: rtl/dffse_bank_ctrl_pkg.sv
// Shared types and helpers for the DFFSE bank write controller.
// Holds the state encoding, a constant clog2 and a one-hot decoder.
package dffse_bank_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PRESET = 1'b1
  } state_t;

  localparam int ONEHOT_MAX = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Address/pointer widths never drop below one bit, even for a single entry.
  function automatic int clog2_min1(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx);
    logic [ONEHOT_MAX-1:0] v;
    v = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/dffse_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping around; returns a one-hot grant and the granted index.
module dffse_rr_arbiter
  import dffse_bank_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int              cand;
    logic            found;
    logic [NREQ-1:0] shifted;
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found = 1'b1;
        gnt   = {{(NREQ-1){1'b0}}, 1'b1} << cand;
        idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/dffse_bank_ctrl.sv
// Write controller sharing one DFFSE register bank among NREQ requesters,
// with a rate-limited one-register-per-cycle preset sweep.
module dffse_bank_ctrl
  import dffse_bank_ctrl_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 8,
  parameter bit INIT_PRESET = 1'b1,
  parameter int AW          = clog2_min1(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*AW-1:0]    ADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       GNT,
  input  logic                  PRESET_REQ,
  output logic                  PRESET_BUSY,
  output logic [DEPTH-1:0]      BANK_CE,
  output logic [DEPTH-1:0]      BANK_SET,
  output logic [WIDTH-1:0]      BANK_D,
  output logic                  ADDR_ERR,
  output state_t                dbg_state
);

  localparam int PW = clog2_min1(NREQ);

  // Handshake: REQ[i] is held until granted; REQ[i] & GNT[i] in a cycle is a
  // transfer, and the write appears on the BANK_* registers one cycle later.

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [AW-1:0]   cnt;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            xfer;
  logic [AW-1:0]   gaddr;
  logic [WIDTH-1:0] gdata;
  logic            addr_ok;
  logic [DEPTH-1:0] ce_next;
  logic [DEPTH-1:0] set_next;
  logic [PW-1:0]   ptr_next;

  dffse_rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_arb (
    .req(REQ),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  always_comb begin
    GNT      = (state == ST_IDLE && !PRESET_REQ) ? arb_gnt : '0;
    xfer     = |GNT;
    gaddr    = ADDR[int'(arb_idx)*AW +: AW];
    gdata    = WDATA[int'(arb_idx)*WIDTH +: WIDTH];
    addr_ok  = int'(gaddr) < DEPTH;
    ce_next  = DEPTH'(onehot(int'(gaddr)));
    set_next = DEPTH'(onehot(int'(cnt)));
    ptr_next = (int'(arb_idx) == NREQ-1) ? '0 : arb_idx + 1'b1;
  end

  assign PRESET_BUSY = (state == ST_PRESET);
  assign dbg_state   = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= INIT_PRESET ? ST_PRESET : ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      BANK_CE  <= '0;
      BANK_SET <= '0;
      BANK_D   <= '0;
      ADDR_ERR <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; only the active branch raises one.
      BANK_CE  <= '0;
      BANK_SET <= '0;
      ADDR_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (PRESET_REQ) begin
            state <= ST_PRESET;
            cnt   <= '0;
          end else if (xfer) begin
            ptr    <= ptr_next;
            BANK_D <= gdata;
            if (addr_ok) BANK_CE  <= ce_next;
            else         ADDR_ERR <= 1'b1;
          end
        end
        ST_PRESET: begin
          BANK_SET <= set_next;
          if (int'(cnt) == DEPTH-1) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffse_bank_ctrl.sv
// Bench for dffse_bank_ctrl: directed steps plus random traffic checked
// against a cycle-level behavioural model; two instances cover both INIT_PRESET settings.
module tb_dffse_bank_ctrl;
  import dffse_bank_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int DA = 6;
  localparam int DB = 8;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int EW = DA + DA + W + 1;

  logic CLK, RESET;
  logic [NR-1:0] req, req_b;
  logic [AW-1:0] addr_arr [NR];
  logic [W-1:0]  wdata_arr [NR];
  logic [NR*AW-1:0] addr_bus;
  logic [NR*W-1:0]  wdata_bus;
  logic preset_req, preset_b;

  logic [NR-1:0] GNT_a, GNT_b;
  logic BUSY_a, BUSY_b, ERR_a, ERR_b;
  logic [DA-1:0] CE_a, SET_a;
  logic [DB-1:0] CE_b, SET_b;
  logic [W-1:0] D_a, D_b;
  state_t st_a, st_b;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ptr, m_idx, m_b_idx;
  bit m_sweep, m_b_sweep;
  logic [W-1:0] m_d;
  logic [DB-1:0] m_b_set;
  logic [EW-1:0] exp_q[$];
  bit drop_on_grant;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < NR; i++) begin
      addr_bus[i*AW +: AW] = addr_arr[i];
      wdata_bus[i*W +: W]  = wdata_arr[i];
    end
  end

  dffse_bank_ctrl #(.NREQ(NR), .DEPTH(DA), .WIDTH(W), .INIT_PRESET(1'b1)) u_a (
    .CLK(CLK), .RESET(RESET), .REQ(req), .ADDR(addr_bus), .WDATA(wdata_bus),
    .GNT(GNT_a), .PRESET_REQ(preset_req), .PRESET_BUSY(BUSY_a),
    .BANK_CE(CE_a), .BANK_SET(SET_a), .BANK_D(D_a), .ADDR_ERR(ERR_a), .dbg_state(st_a)
  );

  dffse_bank_ctrl #(.NREQ(NR), .DEPTH(DB), .WIDTH(W), .INIT_PRESET(1'b0)) u_b (
    .CLK(CLK), .RESET(RESET), .REQ(req_b), .ADDR(addr_bus), .WDATA(wdata_bus),
    .GNT(GNT_b), .PRESET_REQ(preset_b), .PRESET_BUSY(BUSY_b),
    .BANK_CE(CE_b), .BANK_SET(SET_b), .BANK_D(D_b), .ADDR_ERR(ERR_b), .dbg_state(st_b)
  );

  // clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin search from the model pointer; -1 when nothing can be granted.
  function automatic int model_grant();
    if (m_sweep || preset_req) return -1;
    for (int off = 0; off < NR; off++) begin
      int k;
      k = (m_ptr + off) % NR;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update(input int k);
    logic [DA-1:0] nset, nce;
    logic nerr;
    nset = '0; nce = '0; nerr = 1'b0;
    if (m_sweep) begin
      nset = DA'(1 << m_idx);
      m_idx++;
      if (m_idx == DA) m_sweep = 0;
    end else if (preset_req) begin
      m_sweep = 1; m_idx = 0;
    end else if (k >= 0) begin
      m_ptr = (k + 1) % NR;
      m_d   = wdata_arr[k];
      if (int'(addr_arr[k]) < DA) nce = DA'(1 << addr_arr[k]);
      else nerr = 1'b1;
    end
    exp_q.push_back({nset, nce, m_d, nerr});
    if (m_b_sweep) begin
      m_b_set = DB'(1 << m_b_idx);
      m_b_idx++;
      if (m_b_idx == DB) m_b_sweep = 0;
    end else begin
      m_b_set = '0;
      if (preset_b) begin m_b_sweep = 1; m_b_idx = 0; end
    end
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, return at negedge.
  task automatic cycle();
    int k;
    logic [EW-1:0] w;
    #1;
    k = model_grant();
    chk("gnt_a", GNT_a, (k >= 0) ? (1 << k) : 0);
    chk("busy_a", BUSY_a, m_sweep);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected>0", exp_q.size());
    end
    w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("set_a", SET_a, w[EW-1 -: DA]);
    chk("ce_a", CE_a, w[EW-1-DA -: DA]);
    chk("d_a", D_a, w[W:1]);
    chk("err_a", ERR_a, w[0]);
    chk("busy_b", BUSY_b, m_b_sweep);
    chk("set_b", SET_b, m_b_set);
    chk("ce_b", CE_b, 0);
    chk("gnt_b", GNT_b, 0);
    @(posedge CLK);
    model_update(k);
    @(negedge CLK);
    if (drop_on_grant && k >= 0) req[k] = 1'b0;
  endtask

  task automatic apply_reset(input bit async_mid);
    if (async_mid) begin
      @(posedge CLK);
      #3;
    end
    RESET = 1'b1;
    #1;
    chk("rst_set_a", SET_a, 0);
    chk("rst_ce_a", CE_a, 0);
    chk("rst_d_a", D_a, 0);
    chk("rst_err_a", ERR_a, 0);
    chk("rst_busy_a", BUSY_a, 1);
    chk("rst_gnt_a", GNT_a, 0);
    chk("rst_set_b", SET_b, 0);
    chk("rst_busy_b", BUSY_b, 0);
    m_ptr = 0; m_sweep = 1; m_idx = 0; m_d = '0;
    m_b_sweep = 0; m_b_idx = 0; m_b_set = '0;
    exp_q.delete();
    exp_q.push_back('0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic set_ordered_inputs();
    for (int i = 0; i < NR; i++) begin
      addr_arr[i]  = AW'(i);
      wdata_arr[i] = W'(8'hA0 + i);
    end
  endtask

  initial begin
    RESET = 1'b0; req = '0; req_b = '0; preset_req = 1'b0; preset_b = 1'b0;
    drop_on_grant = 1'b0;
    set_ordered_inputs();
    #2;
    apply_reset(1'b0);

    // power-up sweep then idle
    repeat (DA + 2) cycle();

    // all requesters held: grant rotates 0,1,2,3,0,1
    req = 4'b1111;
    repeat (6) cycle();
    req = '0;
    repeat (2) cycle();

    // out-of-range address from requester 2, then pointer must sit at 3
    drop_on_grant = 1'b1;
    addr_arr[2] = 3'd7;
    req = 4'b0100;
    repeat (3) cycle();
    addr_arr[2] = 3'd2;
    req = 4'b1111;
    cycle();
    req = '0;
    cycle();

    // preset request beats a pending write; write lands after the sweep
    req = 4'b0010;
    preset_req = 1'b1;
    preset_b = 1'b1;
    cycle();
    preset_req = 1'b0;
    preset_b = 1'b0;
    repeat (DB + 3) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]       = 1'b1;
          addr_arr[i]  = AW'($urandom_range(0, 7));
          wdata_arr[i] = W'($urandom);
        end
      end
      preset_req = ($urandom_range(0, 39) == 0);
      preset_b   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    req = '0; preset_req = 1'b0; preset_b = 1'b0;
    repeat (DB + 4) cycle();

    // async reset in the middle of a sweep
    set_ordered_inputs();
    preset_req = 1'b1;
    preset_b = 1'b1;
    cycle();
    preset_req = 1'b0;
    preset_b = 1'b0;
    repeat (3) cycle();
    apply_reset(1'b1);
    repeat (DA + 3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
